// File: rtl/control_word_sequencer_if.sv
// Sequencer bus: run/load commands, datapath status and the issued control word.
interface control_word_sequencer_if #(
    parameter int REG_AW = 3,
    parameter int FS_W   = 4,
    parameter int DEPTH  = 8
);
    localparam int PC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW_W = 3*REG_AW + FS_W + 8 + PC_W;

    logic              Start;
    logic              Stop;
    logic              LoadEn;
    logic [PC_W-1:0]   LoadAddr;
    logic [CW_W-1:0]   LoadData;
    logic              Zero;
    logic              Negative;
    logic [REG_AW-1:0] DataReg_A;
    logic [REG_AW-1:0] AddressReg_A;
    logic [REG_AW-1:0] AddressReg_B;
    logic [FS_W-1:0]   FunctionSelect;
    logic              MemoryBus;
    logic              MemoryData;
    logic              ReadWrite;
    logic              MemoryWrite;
    logic [PC_W-1:0]   ProgramCounter;
    logic              Busy;
    logic              Halted;
    logic              LoadErr;

    modport master (
        output Start, Stop, LoadEn, LoadAddr, LoadData, Zero, Negative,
        input  DataReg_A, AddressReg_A, AddressReg_B, FunctionSelect, MemoryBus,
               MemoryData, ReadWrite, MemoryWrite, ProgramCounter, Busy, Halted, LoadErr
    );

    modport slave (
        input  Start, Stop, LoadEn, LoadAddr, LoadData, Zero, Negative,
        output DataReg_A, AddressReg_A, AddressReg_B, FunctionSelect, MemoryBus,
               MemoryData, ReadWrite, MemoryWrite, ProgramCounter, Busy, Halted, LoadErr
    );
endinterface

// File: rtl/control_word_sequencer.sv
// Microcode sequencer: loadable control store, one registered control word per cycle.
// Optional SEQ_SINGLE_STEP_EN adds a Step input gating each issue in RUN.
module control_word_sequencer #(
    parameter int REG_AW = 3,
    parameter int FS_W   = 4,
    parameter int DEPTH  = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic Step,
`endif
    control_word_sequencer_if.slave bus
);
    localparam int PC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [REG_AW-1:0] da;
        logic [REG_AW-1:0] aa;
        logic [REG_AW-1:0] ba;
        logic [FS_W-1:0]   fs;
        logic              mb;
        logic              md;
        logic              rw;
        logic              mw;
        logic              pl;
        logic              jb;
        logic              bc;
        logic              hlt;
        logic [PC_W-1:0]   tgt;
    } cwT;

    typedef struct packed {
        logic [REG_AW-1:0] da;
        logic [REG_AW-1:0] aa;
        logic [REG_AW-1:0] ba;
        logic [FS_W-1:0]   fs;
        logic              mb;
        logic              md;
        logic              rw;
        logic              mw;
    } ctlT;

    typedef enum logic [1:0] {stIdle, stRun, stHalted} stateT;

    stateT           state, nextState;
    cwT              store [DEPTH];
    cwT              word;
    ctlT             ctl;
    logic [PC_W-1:0] pc, nextPc, pcOut;
    logic            haltPend, loadErr;
    logic            issue, quiesce, restart, stepOk, branchTaken;

`ifdef SEQ_SINGLE_STEP_EN
    assign stepOk = Step;
`else
    assign stepOk = 1'b1;
`endif

    assign word = store[pc];

    always_comb begin
        branchTaken = word.bc ? bus.Negative : bus.Zero;
        if (word.pl && (word.jb || branchTaken))
            nextPc = word.tgt;
        else if (pc == PC_W'(DEPTH - 1))
            nextPc = '0;
        else
            nextPc = pc + 1'b1;
    end

    // A halting word stays on the outputs for one cycle; the following edge parks the FSM.
    always_comb begin
        nextState = state;
        issue     = 1'b0;
        quiesce   = 1'b0;
        restart   = 1'b0;
        case (state)
            stRun: begin
                if (bus.Stop) begin
                    nextState = stIdle;
                    quiesce   = 1'b1;
                end else if (haltPend) begin
                    nextState = stHalted;
                    quiesce   = 1'b1;
                end else if (stepOk) begin
                    issue = 1'b1;
                end else begin
                    quiesce = 1'b1;
                end
            end
            default: begin
                if (bus.Stop) begin
                    nextState = stIdle;
                end else if (bus.Start) begin
                    nextState = stRun;
                    restart   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= stIdle;
        else        state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl      <= '0;
            pc       <= '0;
            pcOut    <= '0;
            haltPend <= 1'b0;
            loadErr  <= 1'b0;
        end else begin
            if (issue) begin
                ctl      <= {word.da, word.aa, word.ba, word.fs, word.mb, word.md, word.rw, word.mw};
                pcOut    <= pc;
                pc       <= nextPc;
                haltPend <= word.hlt;
            end else if (quiesce) begin
                ctl.rw <= 1'b0;
                ctl.mw <= 1'b0;
            end
            if (restart) begin
                pc       <= '0;
                haltPend <= 1'b0;
            end
            if (bus.LoadEn && state == stRun)
                loadErr <= 1'b1;
        end
    end

    // Store is deliberately not reset; writes only land outside RUN.
    always_ff @(posedge clk) begin
        if (rst_n && bus.LoadEn && state != stRun && int'(bus.LoadAddr) < DEPTH)
            store[bus.LoadAddr] <= cwT'(bus.LoadData);
    end

    assign bus.DataReg_A      = ctl.da;
    assign bus.AddressReg_A   = ctl.aa;
    assign bus.AddressReg_B   = ctl.ba;
    assign bus.FunctionSelect = ctl.fs;
    assign bus.MemoryBus      = ctl.mb;
    assign bus.MemoryData     = ctl.md;
    assign bus.ReadWrite      = ctl.rw;
    assign bus.MemoryWrite    = ctl.mw;
    assign bus.ProgramCounter = pcOut;
    assign bus.Busy           = (state == stRun);
    assign bus.Halted         = (state == stHalted);
    assign bus.LoadErr        = loadErr;
endmodule

// File: tb/tb_control_word_sequencer.sv
// Bench for control_word_sequencer: directed program scenarios plus random traffic vs a reference model.
module tb_control_word_sequencer;
    localparam int REG_AW = 3;
    localparam int FS_W   = 4;
    localparam int DEPTH  = 8;
    localparam int PC_W   = 3;
    localparam int CW_W   = 3*REG_AW + FS_W + 8 + PC_W;

    logic gclk = 1'b0;
    logic grst_n;
    logic stepIn;
    int   nCmp = 0;
    int   nBad = 0;

    always #5 gclk = ~gclk;

    control_word_sequencer_if #(.REG_AW(REG_AW), .FS_W(FS_W), .DEPTH(DEPTH)) bus ();

    control_word_sequencer #(.REG_AW(REG_AW), .FS_W(FS_W), .DEPTH(DEPTH)) dut (
        .clk   (gclk),
        .rst_n (grst_n),
`ifdef SEQ_SINGLE_STEP_EN
        .Step  (stepIn),
`endif
        .bus   (bus)
    );

    // reference model state
    bit [CW_W-1:0] mMem [DEPTH];
    int            mMode = 0;   // 0 idle, 1 run, 2 halted
    int            mPc = 0;
    bit            mHaltNext = 1'b0;
    logic [2:0]    eDa = '0, eAa = '0, eBa = '0, ePc = '0;
    logic [3:0]    eFs = '0;
    logic          eMb = 1'b0, eMd = 1'b0, eRw = 1'b0, eMw = 1'b0, eErr = 1'b0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW_W-1:0] mk(int da, int aa, int ba, int fs, int mb, int md,
                                           int rw, int mw, int pl, int jb, int bc, int hlt, int tgt);
        longint v;
        v = da;
        v = v*8 + aa;  v = v*8 + ba;  v = v*16 + fs;
        v = v*2 + mb;  v = v*2 + md;  v = v*2 + rw;  v = v*2 + mw;
        v = v*2 + pl;  v = v*2 + jb;  v = v*2 + bc;  v = v*2 + hlt;
        v = v*8 + tgt;
        return CW_W'(v);
    endfunction

    function automatic int fld(bit [CW_W-1:0] w, int lsb, int wid);
        longint v;
        v = longint'(w);
        return int'((v >> lsb) % (longint'(1) << wid));
    endfunction

    function automatic logic [63:0] obsVec();
        return 64'({bus.DataReg_A, bus.AddressReg_A, bus.AddressReg_B, bus.FunctionSelect,
                    bus.MemoryBus, bus.MemoryData, bus.ReadWrite, bus.MemoryWrite,
                    bus.ProgramCounter, bus.Busy, bus.Halted, bus.LoadErr});
    endfunction

    function automatic logic [63:0] expVec();
        return 64'({eDa, eAa, eBa, eFs, eMb, eMd, eRw, eMw, ePc,
                    (mMode == 1), (mMode == 2), eErr});
    endfunction

    task automatic modelEdge();
        bit [CW_W-1:0] w;
        bit cond;
        if (!grst_n) begin
            mMode = 0; mPc = 0; mHaltNext = 1'b0;
            eDa = '0; eAa = '0; eBa = '0; eFs = '0; ePc = '0;
            eMb = 1'b0; eMd = 1'b0; eRw = 1'b0; eMw = 1'b0; eErr = 1'b0;
        end else begin
            if (bus.LoadEn) begin
                if (mMode == 1) eErr = 1'b1;
                else if (int'(bus.LoadAddr) < DEPTH) mMem[bus.LoadAddr] = bus.LoadData;
            end
            if (mMode == 1) begin
                if (bus.Stop) begin
                    mMode = 0; eRw = 1'b0; eMw = 1'b0;
                end else if (mHaltNext) begin
                    mMode = 2; eRw = 1'b0; eMw = 1'b0;
                end else if (stepIn) begin
                    w   = mMem[mPc];
                    eDa = 3'(fld(w, 21, 3)); eAa = 3'(fld(w, 18, 3)); eBa = 3'(fld(w, 15, 3));
                    eFs = 4'(fld(w, 11, 4));
                    eMb = 1'(fld(w, 10, 1)); eMd = 1'(fld(w, 9, 1));
                    eRw = 1'(fld(w, 8, 1));  eMw = 1'(fld(w, 7, 1));
                    ePc = 3'(mPc);
                    mHaltNext = 1'(fld(w, 3, 1));
                    cond = (fld(w, 4, 1) == 1) ? bus.Negative : bus.Zero;
                    if (fld(w, 6, 1) == 1 && (fld(w, 5, 1) == 1 || cond))
                        mPc = fld(w, 0, 3);
                    else
                        mPc = (mPc + 1) % DEPTH;
                end else begin
                    eRw = 1'b0; eMw = 1'b0;
                end
            end else begin
                if (bus.Stop) mMode = 0;
                else if (bus.Start) begin mMode = 1; mPc = 0; mHaltNext = 1'b0; end
            end
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        modelEdge();
        @(negedge gclk);
        chk("cyc", obsVec(), expVec());
    endtask

    task automatic ld(int a, logic [CW_W-1:0] d);
        bus.LoadEn   = 1'b1;
        bus.LoadAddr = PC_W'(a);
        bus.LoadData = d;
        tick();
        bus.LoadEn   = 1'b0;
    endtask

    task automatic startRun();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    initial begin
        int seq [8] = '{0, 1, 2, 5, 6, 7, 0, 1};
        bit seen;
        grst_n = 1'b0; stepIn = 1'b1;
        bus.Start = 1'b0; bus.Stop = 1'b0; bus.LoadEn = 1'b0; bus.LoadAddr = '0;
        bus.LoadData = '0; bus.Zero = 1'b0; bus.Negative = 1'b0;
        tick(); tick();
        chk("rst_out", obsVec(), 64'd0);
        grst_n = 1'b1;

        // sequential fetch, halt and restart, stop
        ld(0, mk(2, 3, 0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        ld(1, mk(2, 2, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        ld(2, mk(3, 2, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        ld(3, mk(1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        for (int a = 4; a < 8; a++) ld(a, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        startRun();
        chk("t1_busy", bus.Busy, 1);
        tick();
        chk("t1_w0", {bus.DataReg_A, bus.AddressReg_A, bus.FunctionSelect, bus.MemoryData,
                      bus.ReadWrite, bus.ProgramCounter}, {3'd2, 3'd3, 4'd5, 1'b1, 1'b1, 3'd0});
        tick();
        chk("t1_w1", {bus.DataReg_A, bus.AddressReg_A, bus.AddressReg_B, bus.FunctionSelect,
                      bus.MemoryBus, bus.ReadWrite, bus.ProgramCounter},
                     {3'd2, 3'd2, 3'd1, 4'd2, 1'b1, 1'b1, 3'd1});
        tick();
        chk("t1_w2", {bus.DataReg_A, bus.AddressReg_A, bus.AddressReg_B, bus.FunctionSelect,
                      bus.ReadWrite, bus.ProgramCounter}, {3'd3, 3'd2, 3'd3, 4'd1, 1'b1, 3'd2});
        tick();
        chk("t4_hltword", {bus.ProgramCounter, bus.MemoryWrite, bus.Busy}, {3'd3, 1'b1, 1'b1});
        tick();
        chk("t4_halted", {bus.Halted, bus.Busy, bus.ReadWrite, bus.MemoryWrite, bus.ProgramCounter},
                         {4'b1000, 3'd3});
        startRun();
        tick();
        chk("t4_restart", {bus.ProgramCounter, bus.DataReg_A}, {3'd0, 3'd2});
        tick(); tick();
        chk("t5_atpc2", bus.ProgramCounter, 2);
        bus.Stop = 1'b1;
        tick();
        bus.Stop = 1'b0;
        chk("t5_stop", {bus.Busy, bus.Halted, bus.ReadWrite, bus.MemoryWrite, bus.DataReg_A},
                       {4'b0000, 3'd3});

        // jump and modulo wrap
        ld(0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        ld(1, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        ld(2, mk(2, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 5));
        ld(3, mk(7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        ld(4, mk(7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        for (int a = 5; a < 8; a++) ld(a, mk(a, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        startRun();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_pc", bus.ProgramCounter, 64'(seq[i]));
        end
        bus.Stop = 1'b1; tick(); bus.Stop = 1'b0;

        // conditional branch on Zero (bc=0) and Negative (bc=1), taken and not taken
        for (int c = 0; c < 4; c++) begin
            int bc, cnd;
            bc  = c / 2;
            cnd = c % 2;
            ld(0, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            ld(1, mk(2, 0, 0, 0, 0, 0, 1, 0, 1, 0, bc, 0, 6));
            ld(2, mk(3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
            ld(6, mk(6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
            bus.Zero     = (bc == 1) ? (cnd == 0) : (cnd == 1);
            bus.Negative = (bc == 1) ? (cnd == 1) : (cnd == 0);
            startRun();
            tick(); tick(); tick();
            chk("t3_br", bus.ProgramCounter, (cnd == 1) ? 64'd6 : 64'd2);
            tick();
            chk("t3_halt", bus.Halted, 1);
        end

        // load and start in the same cycle, then start+stop collision
        bus.LoadEn = 1'b1; bus.LoadAddr = '0;
        bus.LoadData = mk(5, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        bus.Start = 1'b1;
        tick();
        bus.LoadEn = 1'b0; bus.Start = 1'b0;
        tick();
        chk("ld_start", {bus.DataReg_A, bus.ProgramCounter}, {3'd5, 3'd0});
        tick();
        bus.Start = 1'b1; bus.Stop = 1'b1;
        tick();
        bus.Start = 1'b0; bus.Stop = 1'b0;
        chk("start_stop", {bus.Busy, bus.Halted}, 2'b00);

        // load during run is rejected and flagged; reset mid-run
        for (int a = 0; a < 8; a++) ld(a, mk(a, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        startRun();
        tick(); tick();
        bus.LoadEn = 1'b1; bus.LoadAddr = '0;
        bus.LoadData = mk(7, 7, 7, 7, 1, 1, 1, 1, 0, 0, 0, 1, 0);
        tick();
        bus.LoadEn = 1'b0;
        chk("t5_lerr", bus.LoadErr, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!seen && bus.ProgramCounter == 3'd0) begin
                chk("t5_store", {bus.DataReg_A, bus.Halted}, {3'd0, 1'b0});
                seen = 1'b1;
            end
        end
        chk("t5_wrap", seen, 1);
        grst_n = 1'b0;
        tick();
        chk("t5_rst", obsVec(), 64'd0);
        grst_n = 1'b1;
        tick();
        chk("t5_post", {bus.Busy, bus.ProgramCounter, bus.ReadWrite}, 5'd0);

`ifdef SEQ_SINGLE_STEP_EN
        begin
            int steps;
            steps = 0;
            startRun();
            for (int i = 0; i < 12; i++) begin
                stepIn = (i % 3 == 0);
                tick();
                if (stepIn) steps++;
                chk("t6_pc", bus.ProgramCounter, 64'((steps - 1) % DEPTH));
                chk("t6_we", {bus.ReadWrite, bus.MemoryWrite}, stepIn ? 2'b11 : 2'b00);
            end
            stepIn = 1'b1;
            bus.Stop = 1'b1; tick(); bus.Stop = 1'b0;
        end
`endif

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            bus.Start    = ($urandom_range(0, 7) == 0);
            bus.Stop     = ($urandom_range(0, 19) == 0);
            bus.LoadEn   = ($urandom_range(0, 9) == 0);
            bus.LoadAddr = PC_W'($urandom);
            bus.LoadData = CW_W'($urandom);
            bus.Zero     = 1'($urandom);
            bus.Negative = 1'($urandom);
            grst_n       = ($urandom_range(0, 99) != 0);
`ifdef SEQ_SINGLE_STEP_EN
            stepIn = 1'($urandom);
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
